// File: rtl/io_input_conditioner_pkg.sv
// Shared widths and types for the board-input conditioner.
package io_cond_pkg;

   localparam int unsigned IO_SW_W      = 32;
   localparam int unsigned N_SW_DEF     = 10;
   localparam int unsigned N_KEY_DEF    = 4;
   localparam int unsigned DEBOUNCE_DEF = 100_000;

   typedef logic [IO_SW_W-1:0] io_sw_t;

endpackage : io_cond_pkg

// File: rtl/io_input_conditioner_if.sv
// Raw board pins in, conditioned switch word and key/switch pulses out.
interface io_input_conditioner_if
   import io_cond_pkg::*;
#(
   parameter int unsigned N_SW  = N_SW_DEF,
   parameter int unsigned N_KEY = N_KEY_DEF
);

   logic [N_SW-1:0]  i_sw;
   logic [N_KEY-1:0] i_key_n;
   io_sw_t           o_io_sw;
   logic [N_KEY-1:0] o_key_press;
   logic [N_KEY-1:0] o_key_release;
   logic             o_sw_changed;

   modport master (
      output i_sw, i_key_n,
      input  o_io_sw, o_key_press, o_key_release, o_sw_changed
   );

   modport slave (
      input  i_sw, i_key_n,
      output o_io_sw, o_key_press, o_key_release, o_sw_changed
   );

endinterface : io_input_conditioner_if

// File: rtl/io_input_conditioner_debounce_bit.sv
// One input bit: synchroniser chain followed by a saturating stability counter.
// Output level is normalised so that 1 always means "active" (up / pressed).
module debounce_bit #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter logic        RESET_VAL       = 1'b0
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_raw,
   output logic o_stable,
   output logic o_rise_c,
   output logic o_fall_c
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   if (SYNC_STAGES < 2) begin : g_sync_err
      $error("debounce_bit: SYNC_STAGES must be >= 2");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_deb_err
      $error("debounce_bit: DEBOUNCE_CYCLES must be >= 1");
   end

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   sync_lvl;
   logic                   accept_c;

   // XOR with the idle level maps both polarities onto 1 = active
   assign sync_d   = {sync_q[SYNC_STAGES-2:0], i_raw};
   assign sync_lvl = sync_q[SYNC_STAGES-1] ^ RESET_VAL;

   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      accept_c = 1'b0;
      if (sync_lvl == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         stable_d = sync_lvl;
         cnt_d    = '0;
         accept_c = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         sync_q   <= {SYNC_STAGES{RESET_VAL}};
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign o_stable = stable_q;
   assign o_rise_c = accept_c & sync_lvl;
   assign o_fall_c = accept_c & ~sync_lvl;

endmodule : debounce_bit

// File: rtl/io_input_conditioner.sv
// Conditions raw slide switches and active-low keys into the core's switch word,
// plus registered one-cycle press/release/change pulses.
module io_input_conditioner
   import io_cond_pkg::*;
#(
   parameter int unsigned N_SW            = N_SW_DEF,
   parameter int unsigned N_KEY           = N_KEY_DEF,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   io_input_conditioner_if.slave  bus
);

   if (N_SW + N_KEY > IO_SW_W) begin : g_width_err
      $error("io_input_conditioner: N_SW + N_KEY must fit in the 32-bit switch word");
   end

   logic [N_SW-1:0]  sw_stable, sw_rise, sw_fall;
   logic [N_KEY-1:0] key_stable, key_rise, key_fall;
   logic [N_KEY-1:0] press_q, release_q;
   logic             changed_q;

   for (genvar g = 0; g < N_SW; g++) begin : g_sw
      debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (1'b0)
      ) u_db (
         .i_clk    (i_clk),
         .i_reset  (i_reset),
         .i_raw    (bus.i_sw[g]),
         .o_stable (sw_stable[g]),
         .o_rise_c (sw_rise[g]),
         .o_fall_c (sw_fall[g])
      );
   end

   // Keys idle high on the pins; the instance inverts after synchronising
   for (genvar g = 0; g < N_KEY; g++) begin : g_key
      debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (1'b1)
      ) u_db (
         .i_clk    (i_clk),
         .i_reset  (i_reset),
         .i_raw    (bus.i_key_n[g]),
         .o_stable (key_stable[g]),
         .o_rise_c (key_rise[g]),
         .o_fall_c (key_fall[g])
      );
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         press_q   <= '0;
         release_q <= '0;
         changed_q <= 1'b0;
      end else begin
         press_q   <= key_rise;
         release_q <= key_fall;
         changed_q <= |(sw_rise | sw_fall);
      end
   end

   assign bus.o_io_sw       = IO_SW_W'({key_stable, sw_stable});
   assign bus.o_key_press   = press_q;
   assign bus.o_key_release = release_q;
   assign bus.o_sw_changed  = changed_q;

endmodule : io_input_conditioner

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_io_input_conditioner;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   io_input_conditioner_if #(.N_SW(10), .N_KEY(4)) bus ();

   io_input_conditioner #(
      .N_SW            (10),
      .N_KEY           (4),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock edge and settle; inputs are driven and outputs sampled here
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] io_sw,
                            input logic [3:0] press, input logic [3:0] rel, input logic chg);
      check({tag, ".io_sw"},   bus.o_io_sw, io_sw);
      check({tag, ".press"},   32'(bus.o_key_press), 32'(press));
      check({tag, ".release"}, 32'(bus.o_key_release), 32'(rel));
      check({tag, ".changed"}, 32'(bus.o_sw_changed), 32'(chg));
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      // 1: reset held with every input active
      rst_n       = 1'b0;
      bus.i_sw    = 10'h3FF;
      bus.i_key_n = 4'h0;
      repeat (4) step();
      check_all("reset_held", 32'h0, 4'h0, 4'h0, 1'b0);
      bus.i_sw    = 10'h000;
      bus.i_key_n = 4'hF;
      step();
      rst_n = 1'b1;
      repeat (8) step();
      check_all("idle_after_reset", 32'h0, 4'h0, 4'h0, 1'b0);

      // 2: clean switch edge, accepted exactly 6 edges later
      bus.i_sw = 10'h001;
      repeat (5) step();
      check_all("sw_clean_early", 32'h0, 4'h0, 4'h0, 1'b0);
      step();
      check_all("sw_clean_accept", 32'h1, 4'h0, 4'h0, 1'b1);
      step();
      check_all("sw_clean_after", 32'h1, 4'h0, 4'h0, 1'b0);

      // 3: bouncing sw[3], two cycles per level, never accepted
      for (int i = 0; i < 10; i++) begin
         bus.i_sw[3] = ~bus.i_sw[3];
         for (int j = 0; j < 2; j++) begin
            step();
            check_all("sw_bounce", 32'h1, 4'h0, 4'h0, 1'b0);
         end
      end
      bus.i_sw[3] = 1'b1;
      repeat (5) step();
      check_all("sw_settle_early", 32'h1, 4'h0, 4'h0, 1'b0);
      step();
      check_all("sw_settle_accept", 32'h9, 4'h0, 4'h0, 1'b1);
      step();
      check_all("sw_settle_after", 32'h9, 4'h0, 4'h0, 1'b0);

      // 4: key 0 press held 20 cycles then release
      bus.i_key_n = 4'b1110;
      repeat (5) step();
      check_all("key_press_early", 32'h9, 4'h0, 4'h0, 1'b0);
      step();
      check_all("key_press_accept", 32'h409, 4'h1, 4'h0, 1'b0);
      for (int i = 0; i < 14; i++) begin
         step();
         check_all("key_hold", 32'h409, 4'h0, 4'h0, 1'b0);
      end
      bus.i_key_n = 4'hF;
      repeat (5) step();
      check_all("key_rel_early", 32'h409, 4'h0, 4'h0, 1'b0);
      step();
      check_all("key_rel_accept", 32'h9, 4'h0, 4'h1, 1'b0);
      step();
      check_all("key_rel_after", 32'h9, 4'h0, 4'h0, 1'b0);

      // 5: simultaneous switch and key changes land on one edge
      bus.i_sw    = 10'h2AA;
      bus.i_key_n = 4'b0101;
      repeat (5) step();
      check_all("simul_early", 32'h9, 4'h0, 4'h0, 1'b0);
      step();
      check_all("simul_accept", 32'h2AAA, 4'b1010, 4'h0, 1'b1);
      step();
      check_all("simul_after", 32'h2AAA, 4'h0, 4'h0, 1'b0);

      // 6: reset three counts into a key-2 press, key still held afterwards
      bus.i_key_n = 4'b0001;
      repeat (5) step();
      check_all("midcnt_before_rst", 32'h2AAA, 4'h0, 4'h0, 1'b0);
      rst_n = 1'b0;
      #1;
      check_all("midcnt_in_rst", 32'h0, 4'h0, 4'h0, 1'b0);
      repeat (2) step();
      check_all("midcnt_rst_held", 32'h0, 4'h0, 4'h0, 1'b0);
      rst_n = 1'b1;
      repeat (5) step();
      check_all("post_rst_early", 32'h0, 4'h0, 4'h0, 1'b0);
      step();
      check_all("post_rst_accept", 32'h3AAA, 4'b1110, 4'h0, 1'b1);
      step();
      check_all("post_rst_after", 32'h3AAA, 4'h0, 4'h0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_io_input_conditioner
